// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide unit for the HI/LO datapath.
// Multiplies go through a MUL_STAGES-deep product pipeline. Divides use a
// 32-iteration restoring divider that works on operand magnitudes. The
// {hi, lo} result is registered and changes only when the FSM enters DONE.
module muldiv_seq #(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic        accept;
  logic        write_mul;
  logic        write_div;

  // divider working registers (magnitudes) and sign-fix flags
  logic [31:0] a_reg;
  logic [31:0] d_reg;
  logic [31:0] q_reg;
  logic [31:0] r_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        dz_reg;

  // signed ops (MULT, DIV) have op[0] = 0
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_a, mul_b, prod_full;
  logic [63:0] mul_result;

  // one restoring-division step and the final sign-corrected result
  logic [32:0] r_sh, diff;
  logic        q_bit;
  logic [31:0] q_step, r_step;
  logic [31:0] quot_fin, rem_fin;

  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;
  assign mul_a = {{32{a_neg}}, a};
  assign mul_b = {{32{b_neg}}, b};
  // low 64 bits of the sign-extended product are the exact signed/unsigned result
  assign prod_full = mul_a * mul_b;

  // Product pipeline: stage 0 captures the product at accept, later stages shift.
  for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : gen_mul
    logic [63:0] stage_reg;
    if (gi == 0) begin : g_first
      // capture the full product of the accepted operands
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stage_reg <= '0;
        else if (accept) stage_reg <= prod_full;
      end
    end else begin : g_next
      // advance the product one stage per cycle
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stage_reg <= '0;
        else stage_reg <= gen_mul[gi-1].stage_reg;
      end
    end
  end

  assign mul_result = gen_mul[MUL_STAGES-1].stage_reg;

  // Next-state logic and FSM outputs; flush in MUL/DIV beats completion.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    write_mul  = 1'b0;
    write_div  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          accept     = 1'b1;
          busy       = 1'b1;
          state_next = op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else if (cnt_reg == 6'(MUL_STAGES - 1)) begin
          write_mul  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else if (cnt_reg == 6'd31) begin
          write_div  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // the hazard unit must never see a stall while the core is in reset
    if (!resetn) busy = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else state_reg <= state_next;
  end

  // Cycle counter for MUL/DIV; restarts at accept and clears on any exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
    end else if ((state_reg == S_MUL || state_reg == S_DIV) && state_next == state_reg) begin
      cnt_reg <= cnt_reg + 6'd1;
    end else begin
      cnt_reg <= '0;
    end
  end

  // One restoring step, plus the sign fix applied in the final iteration.
  always_comb begin
    r_sh   = {r_reg, q_reg[31]};
    diff   = r_sh - {1'b0, d_reg};
    q_bit  = ~diff[32];
    r_step = q_bit ? diff[31:0] : r_sh[31:0];
    q_step = {q_reg[30:0], q_bit};
    quot_fin = neg_q_reg ? (~q_step + 32'd1) : q_step;
    rem_fin  = neg_r_reg ? (~r_step + 32'd1) : r_step;
    // divide by zero: all-ones quotient, dividend passed through as remainder
    if (dz_reg) begin
      quot_fin = 32'hFFFF_FFFF;
      rem_fin  = a_reg;
    end
  end

  // Divider registers: load magnitudes at accept, iterate while in DIV.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg     <= '0;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      d_reg     <= b_mag;
      q_reg     <= a_mag;
      r_reg     <= '0;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      dz_reg    <= (b == 32'd0);
    end else if (state_reg == S_DIV) begin
      q_reg <= q_step;
      r_reg <= r_step;
    end
  end

  // HI/LO result registers, written only on the transition into DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (write_mul) begin
      hi <= mul_result[63:32];
      lo <= mul_result[31:0];
    end else if (write_div) begin
      hi <= rem_fin;
      lo <= quot_fin;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes expected {hi,lo} and
// done cycle for every issued operation, the monitor pops on each done pulse.
module tb_muldiv_seq;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_seq #(.MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          when;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] hold_val = '0;
  int          hold_prints = 0;

  // Reference: plain integer arithmetic on {hi,lo} = product or {rem, quot}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     res;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = '0;
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = ux * uy;
      2'd2: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Monitor: each done must match the oldest expectation; otherwise hi/lo must hold.
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done at cycle %0d: hi=%h lo=%h", cyc, hi, lo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          vectors++;
          if ({hi, lo} !== e.res || cyc != e.when) begin
            miscompares++;
            $display("FAIL result at cycle %0d: got %h (cycle %0d) expected %h (cycle %0d)",
                     cyc, {hi, lo}, cyc, e.res, e.when);
          end
          hold_val = e.res;
        end
      end else if ({hi, lo} !== hold_val) begin
        miscompares++;
        if (hold_prints < 10) begin
          hold_prints++;
          $display("FAIL hold at cycle %0d: got %h expected %h", cyc, {hi, lo}, hold_val);
        end
      end
    end
  end

  // Issue one op and track busy each cycle; fl >= 0 flushes at cycle T+fl.
  // start is left asserted on return, so a following run_op is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int fl);
    int lat;
    lat = o[1] ? 33 : MS + 1;
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b0;
    op = o;
    a = x;
    b = y;
    if (fl < 0) sb_q.push_back('{model(o, x, y), cyc + lat});
    $display("op=%0d a=%h b=%h flush_at=%0d expect=%h", o, x, y, fl, model(o, x, y));
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      flush = (k == fl);
      @(negedge clk);
      chk("busy", 64'(busy), 64'(k < lat));
      if (k == fl) break;
    end
  endtask

  // Idle cycles with start low; nothing may stall.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'(signed'($urandom_range(0, 20)) - 10);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    start = 1'b1;
    #1;
    chk("reset_busy_start", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // directed multiplies (second pair back-to-back)
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1);
    idle(2);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    idle(1);

    // directed divides including overflow and divide-by-zero corners
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(2'd3, 32'd100, 32'd7, -1);
    run_op(2'd3, 32'h0000_1234, 32'd0, -1);
    run_op(2'd2, 32'h0000_1234, 32'd0, -1);
    run_op(2'd2, 32'h8000_1234, 32'd0, -1);
    idle(1);

    // flush mid-divide, then a multiply accepted the very next cycle
    run_op(2'd2, 32'd1000, 32'd3, 10);
    run_op(2'd0, 32'd7, 32'hFFFF_FFFE, -1);
    idle(1);
    // flush mid-multiply, then idle: no stall, no done, hi/lo held
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    idle(3);

    // randomized traffic with occasional flushes and back-to-back issue
    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      int fl;
      o = 2'($urandom_range(0, 3));
      fl = -1;
      if ($urandom_range(0, 7) == 0) fl = $urandom_range(1, o[1] ? 32 : MS);
      run_op(o, rnd_operand(), rnd_operand(), fl);
      if ($urandom_range(0, 1) == 1 || fl >= 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // asynchronous reset in the middle of a divide
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'd2;
    a = 32'd555;
    b = 32'd7;
    $display("op=2 a=%h b=%h reset_at=5", a, b);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    hold_val = '0;
    flush = 1'b1;
    #1;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    // start with flush held must not be accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_accept", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
    run_op(2'd3, 32'd100, 32'd7, -1);
    idle(3);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: got %0d outstanding results expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the HI/LO datapath of the 5-stage MIPS core. It accepts MULT/MULTU/DIV/DIVU from the E stage and runs a pipelined multiplier or a 32-iteration restoring divider. It holds the pipeline via a stall request until the 64-bit {hi, lo} result is ready. The result then flows to M/W as the HI/LO write value consumed by the forwarding logic.

## Interface
- MUL_STAGES, default 2: number of registered multiplier stages, range 1..4.

- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  E stage holds a mul/div instruction; level, held while stalled.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start in IDLE.
- a  in  32  rs operand (multiplicand / dividend); sampled at accept.
- b  in  32  rt operand (multiplier / divisor); sampled at accept.
- flush  in  1  pipeline flush (exception/ERET); aborts the operation in flight.
- busy  out  1  stall request to the hazard unit; combinational.
- done  out  1  result-valid pulse, one cycle.
- hi  out  32  HI result (product[63:32] / remainder).
- lo  out  32  LO result (product[31:0] / quotient).

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: counter counts MUL_STAGES cycles.
  - DIV: counter counts 32 iterations.
  - DONE: one cycle, done=1.
- Accept: in IDLE, start=1 and flush=0.
  - Latch op, a and b.
  - Go to MUL if op[1]=0, else DIV.
- start is ignored in MUL, DIV and DONE. The instruction is still held in E during DONE and must not restart.
- Transitions:
  - MUL → DONE after MUL_STAGES cycles.
  - DIV → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- Multiply:
  - Signed (MULT) or unsigned (MULTU) 32x32→64.
  - hi = product[63:32], lo = product[31:0].
- Divide: restoring, one quotient bit per cycle, operating on magnitudes.
  - Signed DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000 (wraps), hi = 0.
  - Divisor zero, both DIV and DIVU: lo = 0xFFFFFFFF, hi = a. Latency is unchanged (32 cycles).
- hi and lo are registered. They update only on entry to DONE and hold until the next DONE.
- busy = (IDLE & start & ~flush) | MUL | DIV. It is 0 in DONE so the instruction advances together with done.
- done = (state == DONE).
- Flush:
  - In MUL or DIV: next state IDLE, no done, hi/lo unchanged.
  - In IDLE: the request is not accepted.
  - In DONE: no effect; done still pulses.
  - Flush has priority over start.
- Reset (async, resetn=0):
  - state = IDLE, counters = 0, hi = 0, lo = 0, done = 0.
  - busy is forced to 0 while resetn = 0.
  - Reset mid-operation aborts silently.

## Timing
- Accept at cycle T; busy = 1 in cycle T (combinational from start).
- Multiply:
  - busy = 1 for cycles T..T+MUL_STAGES.
  - done = 1 with valid hi/lo at T+MUL_STAGES+1.
  - With default MUL_STAGES=2: done at T+3.
- Divide:
  - busy = 1 for cycles T..T+32.
  - done = 1 at T+33; the sign fix is applied in the last iteration cycle.
- Back-to-back: the earliest next accept is T_done+1, in IDLE.
- Throughput: one operation per MUL_STAGES+2 cycles (multiply) or 34 cycles (divide).
- Flush in cycle F during MUL/DIV: state is IDLE at F+1; a new start can be accepted at F+1.

## Test plan
- MULT: a=0xFFFFFFFD (−3), b=5 at T → done at T+3 only; busy 1 at T..T+2, 0 at T+3; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0, lo=1. The second accept occurs at T+4, the cycle after DONE.
- DIV:
  - a=0xFFFFFFF9 (−7), b=2 → done at T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 100/7 → lo=14, hi=2.
- Divide by zero: DIVU a=0x1234, b=0 → done at T+33, lo=0xFFFFFFFF, hi=0x1234. The same result is required for DIV.
- Flush: DIV started at T, flush=1 at T+10 → busy=0 at T+11, no done pulse ever, hi/lo keep their previous values. A MULT started at T+11 completes at T+14.
- Reset: resetn low at T+5 of a DIV → hi=lo=0, done=0, busy=0 immediately. After release, start with flush=1 is not accepted, and start with flush=0 proceeds normally.
